// File: rtl/pipeline_sequencer.sv
// Global F/D/E/M/W scheduler: merges hazard, memory-wait, mul/div and debug requests into stage enables/clears.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_sequencer #(
  parameter int MD_LATENCY   = 5,
  parameter int DRAIN_CYCLES = 4,
  parameter int BOOT_HALTED  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF_req,
  input  logic        StallD_req,
  input  logic        FlushE_req,
  input  logic        mem_busy,
  input  logic        md_start,
  input  logic        halt_req,
  input  logic        step_req,
  input  logic        resume_req,
  output logic        EnF,
  output logic        EnD,
  output logic        EnE,
  output logic        EnM,
  output logic        EnW,
  output logic        ClrD,
  output logic        ClrE,
  output logic        ClrM,
  output logic        halted,
  output logic        md_busy,
  output logic [2:0]  state,
  output logic [31:0] cycle_cnt,
  output logic [31:0] stall_cnt
);

  localparam int MDW = $clog2(MD_LATENCY + 1);
  localparam int DW  = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_MDWAIT = 3'd1,
    S_DRAIN  = 3'd2,
    S_HALTED = 3'd3,
    S_STEP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [MDW-1:0]   md_cnt_q, md_cnt_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic             halt_pend_q, halt_pend_d;
  logic             en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m;
  logic             state_legal;

  always_comb begin
    en_f = 1'b0; en_d = 1'b0; en_e = 1'b0; en_m = 1'b0; en_w = 1'b0;
    clr_d = 1'b0; clr_e = 1'b0; clr_m = 1'b0;
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    drain_cnt_d = drain_cnt_q;
    halt_pend_d = halt_pend_q;
    state_legal = 1'b1;
    case (state_q)
      S_RUN, S_STEP: begin
        en_f = ~StallF_req;
        en_d = ~StallD_req;
        en_e = 1'b1; en_m = 1'b1; en_w = 1'b1;
        clr_e = FlushE_req;
        // A step that launches a mul/div must still come back to HALTED afterwards.
        if (md_start && !FlushE_req) begin
          state_d     = S_MDWAIT;
          md_cnt_d    = MDW'(MD_LATENCY - 1);
          halt_pend_d = halt_req || (state_q == S_STEP);
        end else if (halt_req || (state_q == S_STEP)) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DW'(DRAIN_CYCLES);
          halt_pend_d = 1'b0;
        end
      end
      S_MDWAIT: begin
        en_m = 1'b1; clr_m = 1'b1; en_w = 1'b1;
        if (halt_req) halt_pend_d = 1'b1;
        if (md_cnt_q == '0) begin
          if (halt_pend_q || halt_req) begin
            state_d     = S_DRAIN;
            drain_cnt_d = DW'(DRAIN_CYCLES);
            halt_pend_d = 1'b0;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          md_cnt_d = md_cnt_q - 1'b1;
        end
      end
      S_DRAIN: begin
        en_d = ~StallD_req;
        clr_d = 1'b1;
        en_e = 1'b1; en_m = 1'b1; en_w = 1'b1;
        clr_e = FlushE_req;
        if (md_start) begin
          state_d     = S_MDWAIT;
          md_cnt_d    = MDW'(MD_LATENCY - 1);
          halt_pend_d = 1'b1;
        end else if (!StallD_req) begin
          if (drain_cnt_q != '0) drain_cnt_d = drain_cnt_q - 1'b1;
          if (drain_cnt_q <= DW'(1)) state_d = S_HALTED;
        end
      end
      S_HALTED: begin
        if (resume_req)    state_d = S_RUN;
        else if (step_req) state_d = S_STEP;
      end
      default: begin
        state_legal = 1'b0;
        state_d     = S_RUN;
      end
    endcase
    // A memory wait freezes the whole pipe; only illegal-state recovery still proceeds.
    if (mem_busy) begin
      en_f = 1'b0; en_d = 1'b0; en_e = 1'b0; en_m = 1'b0; en_w = 1'b0;
      clr_d = 1'b0; clr_e = 1'b0; clr_m = 1'b0;
      state_d     = state_legal ? state_q : S_RUN;
      md_cnt_d    = md_cnt_q;
      drain_cnt_d = drain_cnt_q;
      halt_pend_d = halt_pend_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= (BOOT_HALTED != 0) ? S_HALTED : S_RUN;
      md_cnt_q    <= '0;
      drain_cnt_q <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign EnF     = en_f & rst_n;
  assign EnD     = en_d & rst_n;
  assign EnE     = en_e & rst_n;
  assign EnM     = en_m & rst_n;
  assign EnW     = en_w & rst_n;
  assign ClrD    = clr_d & rst_n;
  assign ClrE    = clr_e & rst_n;
  assign ClrM    = clr_m & rst_n;
  assign halted  = (state_q == S_HALTED);
  assign md_busy = (state_q == S_MDWAIT);
  assign state   = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q != S_HALTED) cycle_cnt_d = cycle_cnt_q + 32'd1;
    // Fetch stalls are only attributed to states that would otherwise fetch.
    if (!EnF && (state_q == S_RUN || state_q == S_STEP || state_q == S_MDWAIT))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign cycle_cnt = 32'd0;
  assign stall_cnt = 32'd0;
`endif

endmodule
